sd_block_writer: RTL and testbench
==================================

Name: sd_block_writer

Overview:
- Write counterpart of the SD block reader: after card init, writes one (CMD24) or several contiguous (CMD25) 512-byte blocks through the shared SPI byte engine.
- Pulls payload bytes from an upstream byte stream (frame buffer / FIFO) with a valid/ready handshake.
- Argument is the LBA for SDHC. For SDSC, the caller pre-scales the address to bytes.

Parameters:
- DATA_DIV, 16'd4, SPI clock divider driven on spi_div (100 MHz / (2*4) = 12.5 MHz).
- WAIT_BYTES, 24'd800000, byte-poll timeout for R1, data response and busy.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- spi_div  out  16  constant DATA_DIV
- spi_start  out  1  one-cycle pulse, start one SPI byte
- spi_mosi  out  8  byte to shift; held stable from spi_start to spi_done
- spi_busy  in  1  engine shifting
- spi_done  in  1  one-cycle pulse, byte complete
- spi_miso  in  8  received byte, valid with spi_done
- sd_cs_n  out  1  card chip select, active low
- start  in  1  pulse, begin transfer (sampled in W_IDLE only)
- multi  in  1  0: CMD24, 1: CMD25; latched at start
- lba_start  in  32  first block address, latched at start
- blocks  in  32  block count for multi; 0 is treated as 1
- din_valid  in  1  upstream byte available
- din_byte  in  8  payload byte
- din_ready  out  1  one-cycle pulse, din_byte consumed this cycle
- block_done  out  1  pulse after each block is accepted and the card is no longer busy
- all_done  out  1  pulse at successful end of transfer
- error  out  1  sticky until next start
- err_code  out  3  0 none, 1 R1 not 0x00, 2 R1 timeout, 3 data response rejected, 4 busy timeout

Behaviour:
- Reset values: sd_cs_n=1, spi_start=0, spi_mosi=8'hFF, din_ready=0, block_done=0, all_done=0, error=0, err_code=0, state=W_IDLE, counters=0.
- A reset mid-transfer aborts immediately with CS high. No stop token is sent.
- SPI rule: spi_start is issued only when !spi_busy && !spi_done. Every issued byte is followed by exactly one spi_done before the next spi_start.
- Default drive is 8'hFF for all poll, gap and CRC bytes.
- W_IDLE: CS high. On start:
  - CS low; latch multi, lba, and blocks_left = (blocks==0) ? 1 : blocks.
  - Clear error and err_code.
  - Go to W_CMD_SEND.
- W_CMD_SEND: send 6 bytes, one per phase: 8'h58 (single) or 8'h59 (multi), lba[31:24], lba[23:16], lba[15:8], lba[7:0], 8'hFF. Then load the timeout and go to W_CMD_R1.
- W_CMD_R1: poll FF bytes, decrementing the timeout per issued byte.
  - miso==8'h00: go to W_GAP.
  - miso is neither 8'h00 nor 8'hFF: err_code=1.
  - Timeout reaches 0: err_code=2.
- W_GAP: send one 8'hFF byte (Nwr), then go to W_TOKEN.
- W_TOKEN: send 8'hFE (single) or 8'hFC (multi), then go to W_DATA with bcnt=0.
- W_DATA: 512 payload bytes.
  - When the engine is free and din_valid=1: drive spi_mosi=din_byte, pulse spi_start and din_ready in the same cycle.
  - When din_valid=0: issue nothing; CS stays low and the SPI clock idles.
  - bcnt increments on each spi_done. After the spi_done with bcnt==511, go to W_CRC.
  - din_ready pulses exactly 512 times per block.
- W_CRC: send 2 bytes of 8'hFF (dummy CRC), then load the timeout and go to W_DRESP.
- W_DRESP: poll until miso != 8'hFF.
  - (miso & 8'h1F)==5'h05: load the timeout and go to W_BUSY.
  - Any other value: err_code=3.
  - Timeout reaches 0: err_code=4.
- W_BUSY: poll until miso != 8'h00.
  - Timeout reaches 0: err_code=4.
  - On release: pulse block_done and go to W_BLK_DONE.
- W_BLK_DONE:
  - Single write: CS high, all_done, go to W_IDLE.
  - Multi with blocks_left==1: go to W_STOP_TOK.
  - Otherwise: lba+1, blocks_left-1, go to W_GAP.
- W_STOP_TOK: send 8'hFD, then one 8'hFF stuff byte. Load the timeout and go to W_STOP_BUSY.
- W_STOP_BUSY: poll until miso != 8'h00.
  - On release: CS high, all_done, go to W_IDLE.
  - Timeout reaches 0: err_code=4.
- Error path: set error, go to W_ERR. W_ERR drives CS high and returns to W_IDLE on the next cycle. error and err_code hold until the next start.
- A start arriving while not in W_IDLE is ignored. block_done and all_done never assert in the same cycle as error.
- Block address is 32-bit and wraps modulo 2^32.

Test Plan:
- Single write, LBA 0x00001234, card model returns R1 0x00, data response 0xE5, then 3 busy bytes of 0x00 before 0xFF -> MOSI sequence 58 00 00 12 34 FF, then FF FE, then 512 data bytes, then FF FF; exactly 512 din_ready pulses; one block_done; all_done; CS high; error=0.
- Multi write, blocks=3, LBA 0x10 -> CMD 59 00 00 00 10 FF; three FC-token frames; 3 block_done pulses; then FD FF, busy poll, all_done; blocks=0 run writes exactly 1 block.
- Upstream stall: din_valid low for 200 cycles after byte 100 -> no spi_start issued during the stall, CS stays low, byte order is preserved, count is still 512.
- R1=0x04 -> error=1, err_code=1, CS high, no din_ready pulses; model never answers and WAIT_BYTES=16 -> err_code=2 after 16 poll bytes.
- Data response 0xEB (CRC error) -> err_code=3 with no block_done; busy held 0x00 beyond WAIT_BYTES=16 -> err_code=4.
- rst asserted during W_DATA at byte 300 -> next cycle all outputs at reset values; a following start performs a clean single write.

Source files
------------

// File: rtl/sd_block_writer.sv
// sd_block_writer
// ----------------
// Writes one (CMD24) or several contiguous (CMD25) 512-byte blocks to an SD
// card in SPI mode. SPI bytes are shifted by a shared byte engine: this
// block issues one byte at a time with a spi_start pulse and waits for the
// matching spi_done before issuing the next. Payload bytes come from an
// upstream valid/ready byte stream.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   spi_div           constant SPI clock divider for the engine
//   spi_start         one-cycle pulse, shift spi_mosi
//   spi_mosi          byte to shift, held from spi_start until spi_done
//   spi_busy          engine is shifting
//   spi_done          one-cycle pulse, byte complete, spi_miso valid
//   spi_miso          byte received from the card
//   sd_cs_n           card chip select, active low
//   start             begin a transfer (only honoured while idle)
//   multi             0: single block, 1: multi block (latched at start)
//   lba_start         first block address (latched at start)
//   blocks            block count for multi, 0 means 1 (latched at start)
//   din_valid         upstream payload byte available
//   din_byte          upstream payload byte
//   din_ready         one-cycle pulse, din_byte consumed
//   block_done        pulse once a block is accepted and the card is idle
//   all_done          pulse at successful end of the transfer
//   error             sticky failure flag, cleared by the next start
//   err_code          1 R1 bad, 2 R1 timeout, 3 data rejected, 4 busy timeout
module sd_block_writer #(
    parameter logic [15:0] DATA_DIV   = 16'd4,
    parameter logic [23:0] WAIT_BYTES = 24'd800000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] spi_div,
    output logic        spi_start,
    output logic [7:0]  spi_mosi,
    input  logic        spi_busy,
    input  logic        spi_done,
    input  logic [7:0]  spi_miso,
    output logic        sd_cs_n,
    input  logic        start,
    input  logic        multi,
    input  logic [31:0] lba_start,
    input  logic [31:0] blocks,
    input  logic        din_valid,
    input  logic [7:0]  din_byte,
    output logic        din_ready,
    output logic        block_done,
    output logic        all_done,
    output logic        error,
    output logic [2:0]  err_code
);

    typedef enum logic [3:0] {
        W_IDLE      = 4'd0,
        W_CMD_SEND  = 4'd1,
        W_CMD_R1    = 4'd2,
        W_GAP       = 4'd3,
        W_TOKEN     = 4'd4,
        W_DATA      = 4'd5,
        W_CRC       = 4'd6,
        W_DRESP     = 4'd7,
        W_BUSY      = 4'd8,
        W_BLK_DONE  = 4'd9,
        W_STOP_TOK  = 4'd10,
        W_STOP_BUSY = 4'd11,
        W_ERR       = 4'd12
    } state_t;

    localparam logic [2:0] ERR_R1_BAD  = 3'd1;
    localparam logic [2:0] ERR_R1_TO   = 3'd2;
    localparam logic [2:0] ERR_DRESP   = 3'd3;
    localparam logic [2:0] ERR_BUSY_TO = 3'd4;

    // Six-byte command frame: opcode, 32-bit address MSB first, dummy CRC.
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx,
                                            input logic       is_multi,
                                            input logic [31:0] addr);
        case (idx)
            3'd0:    cmd_byte = is_multi ? 8'h59 : 8'h58;
            3'd1:    cmd_byte = addr[31:24];
            3'd2:    cmd_byte = addr[23:16];
            3'd3:    cmd_byte = addr[15:8];
            3'd4:    cmd_byte = addr[7:0];
            default: cmd_byte = 8'hFF;
        endcase
    endfunction

    state_t       state_r, state_nx;
    logic [2:0]   phase_r, phase_nx;
    logic [8:0]   bcnt_r, bcnt_nx;
    logic [23:0]  timeout_r, timeout_nx;
    logic [31:0]  lba_r, lba_nx;
    logic [31:0]  blocks_left_r, blocks_left_nx;
    logic         multi_r, multi_nx;
    logic         pending_r, pending_nx;
    logic         spi_start_r, spi_start_nx;
    logic [7:0]   spi_mosi_r, spi_mosi_nx;
    logic         cs_n_r, cs_n_nx;
    logic         din_ready_r, din_ready_nx;
    logic         block_done_r, block_done_nx;
    logic         all_done_r, all_done_nx;
    logic         error_r, error_nx;
    logic [2:0]   err_code_r, err_code_nx;

    logic         can_issue_s;
    logic         byte_done_s;
    logic         want_s;
    logic [7:0]   want_byte_s;
    logic         raise_err_s;
    logic [2:0]   err_sel_s;

    // pending_r covers the gap between our spi_start and the engine raising
    // spi_busy, so a second byte can never be issued before the first done.
    assign can_issue_s = !pending_r && !spi_busy && !spi_done;
    assign byte_done_s = pending_r && spi_done;

    assign spi_div    = DATA_DIV;
    assign spi_start  = spi_start_r;
    assign spi_mosi   = spi_mosi_r;
    assign sd_cs_n    = cs_n_r;
    assign din_ready  = din_ready_r;
    assign block_done = block_done_r;
    assign all_done   = all_done_r;
    assign error      = error_r;
    assign err_code   = err_code_r;

    // State, counters and all outputs are registered; reset returns to idle with CS high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= W_IDLE;
            phase_r       <= 3'd0;
            bcnt_r        <= 9'd0;
            timeout_r     <= 24'd0;
            lba_r         <= 32'd0;
            blocks_left_r <= 32'd0;
            multi_r       <= 1'b0;
            pending_r     <= 1'b0;
            spi_start_r   <= 1'b0;
            spi_mosi_r    <= 8'hFF;
            cs_n_r        <= 1'b1;
            din_ready_r   <= 1'b0;
            block_done_r  <= 1'b0;
            all_done_r    <= 1'b0;
            error_r       <= 1'b0;
            err_code_r    <= 3'd0;
        end else begin
            state_r       <= state_nx;
            phase_r       <= phase_nx;
            bcnt_r        <= bcnt_nx;
            timeout_r     <= timeout_nx;
            lba_r         <= lba_nx;
            blocks_left_r <= blocks_left_nx;
            multi_r       <= multi_nx;
            pending_r     <= pending_nx;
            spi_start_r   <= spi_start_nx;
            spi_mosi_r    <= spi_mosi_nx;
            cs_n_r        <= cs_n_nx;
            din_ready_r   <= din_ready_nx;
            block_done_r  <= block_done_nx;
            all_done_r    <= all_done_nx;
            error_r       <= error_nx;
            err_code_r    <= err_code_nx;
        end
    end

    // Next-state logic: each state names the byte it wants to send (want_s)
    // and reacts to the completion of its previous byte (byte_done_s).
    always_comb begin
        state_nx       = state_r;
        phase_nx       = phase_r;
        bcnt_nx        = bcnt_r;
        timeout_nx     = timeout_r;
        lba_nx         = lba_r;
        blocks_left_nx = blocks_left_r;
        multi_nx       = multi_r;
        pending_nx     = byte_done_s ? 1'b0 : pending_r;
        spi_start_nx   = 1'b0;
        spi_mosi_nx    = spi_mosi_r;
        cs_n_nx        = cs_n_r;
        din_ready_nx   = 1'b0;
        block_done_nx  = 1'b0;
        all_done_nx    = 1'b0;
        error_nx       = error_r;
        err_code_nx    = err_code_r;
        want_s         = 1'b0;
        want_byte_s    = 8'hFF;
        raise_err_s    = 1'b0;
        err_sel_s      = 3'd0;

        case (state_r)
            W_IDLE: begin
                cs_n_nx     = 1'b1;
                spi_mosi_nx = 8'hFF;
                if (start) begin
                    cs_n_nx        = 1'b0;
                    multi_nx       = multi;
                    lba_nx         = lba_start;
                    blocks_left_nx = (blocks == 32'd0) ? 32'd1 : blocks;
                    error_nx       = 1'b0;
                    err_code_nx    = 3'd0;
                    phase_nx       = 3'd0;
                    bcnt_nx        = 9'd0;
                    state_nx       = W_CMD_SEND;
                end else begin
                    state_nx = W_IDLE;
                end
            end

            W_CMD_SEND: begin
                want_s      = 1'b1;
                want_byte_s = cmd_byte(phase_r, multi_r, lba_r);
                if (byte_done_s) begin
                    if (phase_r == 3'd5) begin
                        phase_nx   = 3'd0;
                        timeout_nx = WAIT_BYTES;
                        state_nx   = W_CMD_R1;
                    end else begin
                        phase_nx = phase_r + 3'd1;
                    end
                end else begin
                    state_nx = W_CMD_SEND;
                end
            end

            W_CMD_R1: begin
                want_s = 1'b1;
                if (byte_done_s) begin
                    if (spi_miso == 8'h00) begin
                        state_nx = W_GAP;
                    end else if (spi_miso != 8'hFF) begin
                        raise_err_s = 1'b1;
                        err_sel_s   = ERR_R1_BAD;
                    end else if (timeout_r <= 24'd1) begin
                        raise_err_s = 1'b1;
                        err_sel_s   = ERR_R1_TO;
                    end else begin
                        timeout_nx = timeout_r - 24'd1;
                    end
                end else begin
                    state_nx = W_CMD_R1;
                end
            end

            W_GAP: begin
                want_s = 1'b1;
                if (byte_done_s) begin
                    state_nx = W_TOKEN;
                end else begin
                    state_nx = W_GAP;
                end
            end

            W_TOKEN: begin
                want_s      = 1'b1;
                want_byte_s = multi_r ? 8'hFC : 8'hFE;
                if (byte_done_s) begin
                    bcnt_nx  = 9'd0;
                    state_nx = W_DATA;
                end else begin
                    state_nx = W_TOKEN;
                end
            end

            W_DATA: begin
                // With no upstream byte nothing is issued; the SPI clock idles.
                want_s      = din_valid;
                want_byte_s = din_byte;
                if (byte_done_s) begin
                    if (bcnt_r == 9'd511) begin
                        bcnt_nx  = 9'd0;
                        phase_nx = 3'd0;
                        state_nx = W_CRC;
                    end else begin
                        bcnt_nx = bcnt_r + 9'd1;
                    end
                end else begin
                    state_nx = W_DATA;
                end
            end

            W_CRC: begin
                want_s = 1'b1;
                if (byte_done_s) begin
                    if (phase_r == 3'd1) begin
                        phase_nx   = 3'd0;
                        timeout_nx = WAIT_BYTES;
                        state_nx   = W_DRESP;
                    end else begin
                        phase_nx = phase_r + 3'd1;
                    end
                end else begin
                    state_nx = W_CRC;
                end
            end

            W_DRESP: begin
                want_s = 1'b1;
                if (byte_done_s) begin
                    if (spi_miso != 8'hFF) begin
                        if (spi_miso[4:0] == 5'h05) begin
                            timeout_nx = WAIT_BYTES;
                            state_nx   = W_BUSY;
                        end else begin
                            raise_err_s = 1'b1;
                            err_sel_s   = ERR_DRESP;
                        end
                    end else if (timeout_r <= 24'd1) begin
                        raise_err_s = 1'b1;
                        err_sel_s   = ERR_BUSY_TO;
                    end else begin
                        timeout_nx = timeout_r - 24'd1;
                    end
                end else begin
                    state_nx = W_DRESP;
                end
            end

            W_BUSY: begin
                want_s = 1'b1;
                if (byte_done_s) begin
                    if (spi_miso != 8'h00) begin
                        block_done_nx = 1'b1;
                        state_nx      = W_BLK_DONE;
                    end else if (timeout_r <= 24'd1) begin
                        raise_err_s = 1'b1;
                        err_sel_s   = ERR_BUSY_TO;
                    end else begin
                        timeout_nx = timeout_r - 24'd1;
                    end
                end else begin
                    state_nx = W_BUSY;
                end
            end

            W_BLK_DONE: begin
                if (!multi_r) begin
                    cs_n_nx     = 1'b1;
                    all_done_nx = 1'b1;
                    state_nx    = W_IDLE;
                end else if (blocks_left_r == 32'd1) begin
                    phase_nx = 3'd0;
                    state_nx = W_STOP_TOK;
                end else begin
                    lba_nx         = lba_r + 32'd1;
                    blocks_left_nx = blocks_left_r - 32'd1;
                    state_nx       = W_GAP;
                end
            end

            W_STOP_TOK: begin
                // Stop token followed by one stuff byte before polling busy.
                want_s      = 1'b1;
                want_byte_s = (phase_r == 3'd0) ? 8'hFD : 8'hFF;
                if (byte_done_s) begin
                    if (phase_r == 3'd1) begin
                        phase_nx   = 3'd0;
                        timeout_nx = WAIT_BYTES;
                        state_nx   = W_STOP_BUSY;
                    end else begin
                        phase_nx = phase_r + 3'd1;
                    end
                end else begin
                    state_nx = W_STOP_TOK;
                end
            end

            W_STOP_BUSY: begin
                want_s = 1'b1;
                if (byte_done_s) begin
                    if (spi_miso != 8'h00) begin
                        cs_n_nx     = 1'b1;
                        all_done_nx = 1'b1;
                        state_nx    = W_IDLE;
                    end else if (timeout_r <= 24'd1) begin
                        raise_err_s = 1'b1;
                        err_sel_s   = ERR_BUSY_TO;
                    end else begin
                        timeout_nx = timeout_r - 24'd1;
                    end
                end else begin
                    state_nx = W_STOP_BUSY;
                end
            end

            W_ERR: begin
                cs_n_nx     = 1'b1;
                spi_mosi_nx = 8'hFF;
                state_nx    = W_IDLE;
            end

            default: begin
                cs_n_nx     = 1'b1;
                spi_mosi_nx = 8'hFF;
                state_nx    = W_IDLE;
            end
        endcase

        // Issue the requested byte once the engine is free; payload bytes
        // are acknowledged upstream in the same cycle they are issued.
        if (want_s && can_issue_s) begin
            spi_start_nx = 1'b1;
            spi_mosi_nx  = want_byte_s;
            pending_nx   = 1'b1;
            din_ready_nx = (state_r == W_DATA);
        end else begin
            spi_start_nx = 1'b0;
            din_ready_nx = 1'b0;
        end

        if (raise_err_s) begin
            error_nx    = 1'b1;
            err_code_nx = err_sel_s;
            state_nx    = W_ERR;
        end else begin
            error_nx    = error_nx;
            err_code_nx = err_code_nx;
        end
    end

endmodule

// File: tb/tb_sd_block_writer.sv
// Directed bench for sd_block_writer: a byte-engine model with an SD card
// model behind it, an upstream byte feeder, and hand-derived expected byte
// streams and pulse counts.
module tb_sd_block_writer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] spi_div;
    logic        spi_start;
    logic [7:0]  spi_mosi;
    logic        spi_busy = 1'b0;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_miso = 8'hFF;
    logic        sd_cs_n;
    logic        start;
    logic        multi;
    logic [31:0] lba_start;
    logic [31:0] blocks;
    logic        din_valid = 1'b0;
    logic [7:0]  din_byte = 8'h00;
    logic        din_ready;
    logic        block_done;
    logic        all_done;
    logic        error;
    logic [2:0]  err_code;

    sd_block_writer #(.DATA_DIV(16'd4), .WAIT_BYTES(24'd16)) dut (
        .clk(clk), .rst(rst), .spi_div(spi_div), .spi_start(spi_start),
        .spi_mosi(spi_mosi), .spi_busy(spi_busy), .spi_done(spi_done),
        .spi_miso(spi_miso), .sd_cs_n(sd_cs_n), .start(start), .multi(multi),
        .lba_start(lba_start), .blocks(blocks), .din_valid(din_valid),
        .din_byte(din_byte), .din_ready(din_ready), .block_done(block_done),
        .all_done(all_done), .error(error), .err_code(err_code)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Payload pattern by byte index within a transfer.
    function automatic logic [7:0] pat(input int i);
        int t;
        t = i * 13 + (i / 512) * 5 + 1;
        return t[7:0];
    endfunction

    // Card behaviour knobs
    logic [7:0] r1_val = 8'h00;
    logic [7:0] dresp_val = 8'hE5;
    bit         r1_never = 1'b0;
    bit         busy_forever = 1'b0;
    int         busy_n = 3;

    // Engine + card state
    logic [7:0] mosi_log[$];
    int         eng_cnt = 0;
    logic [7:0] eng_byte = 8'hFF;
    logic [7:0] resp;
    int         viol = 0;
    int         card_st = 0;
    int         card_cnt = 0;
    int         card_busy = 0;

    task automatic card_step(input logic [7:0] m, output logic [7:0] r);
        r = 8'hFF;
        case (card_st)
            0: if (m == 8'h58 || m == 8'h59) begin card_st = 1; card_cnt = 1; end
            1: begin card_cnt++; if (card_cnt == 6) card_st = 2; end
            2: if (!r1_never) begin r = r1_val; card_st = 3; end
            3: begin
                if (m == 8'hFE || m == 8'hFC) begin card_st = 4; card_cnt = 0; end
                else if (m == 8'hFD) card_st = 7;
            end
            4: begin card_cnt++; if (card_cnt == 512) begin card_st = 5; card_cnt = 0; end end
            5: begin card_cnt++; if (card_cnt == 2) card_st = 6; end
            6: begin r = dresp_val; card_st = 8; card_busy = busy_n; end
            8: begin
                if (busy_forever) r = 8'h00;
                else if (card_busy > 0) begin r = 8'h00; card_busy--; end
                else card_st = 3;
            end
            7: begin card_st = 9; card_busy = busy_n; end
            9: begin
                if (card_busy > 0) begin r = 8'h00; card_busy--; end
                else card_st = 0;
            end
            default: card_st = 0;
        endcase
    endtask

    // Byte engine: 4 cycles busy per byte, then a one-cycle done with the card's answer.
    always @(posedge clk) begin
        if (rst) begin
            spi_busy <= 1'b0;
            spi_done <= 1'b0;
            eng_cnt = 0;
            card_st = 0;
        end else begin
            spi_done <= 1'b0;
            if (sd_cs_n) card_st = 0;
            if (spi_start) begin
                if (spi_busy || spi_done || eng_cnt != 0) viol++;
                spi_busy <= 1'b1;
                eng_cnt = 4;
                eng_byte = spi_mosi;
            end else if (eng_cnt != 0) begin
                if (spi_mosi !== eng_byte) viol++;
                eng_cnt--;
                if (eng_cnt == 0) begin
                    card_step(eng_byte, resp);
                    spi_miso <= resp;
                    spi_done <= 1'b1;
                    spi_busy <= 1'b0;
                    mosi_log.push_back(eng_byte);
                end
            end
        end
    end

    // Upstream feeder with an optional 200-cycle stall after 100 bytes.
    bit stall_en = 1'b0;
    int feed_idx = 0, stall_left = 0, stall_hits = 0, stall_starts = 0, stall_cs_bad = 0;
    bit stalled_once = 1'b0;
    always @(negedge clk) begin
        if (sd_cs_n && stall_left > 0) stall_cs_bad++;
        if (sd_cs_n) begin
            feed_idx = 0; stall_left = 0; stalled_once = 1'b0;
            din_valid = 1'b0; din_byte = 8'h00;
        end else begin
            if (din_ready) feed_idx++;
            if (stall_left > 0) begin
                if (spi_start) stall_starts++;
                stall_left--;
            end else if (stall_en && !stalled_once && feed_idx == 100) begin
                stall_left = 200; stalled_once = 1'b1; stall_hits++;
            end
            if (stall_left > 0) din_valid = 1'b0;
            else begin din_valid = 1'b1; din_byte = pat(feed_idx); end
        end
    end

    // Pulse counters
    int rdy_cnt = 0, bd_cnt = 0, ad_cnt = 0, overlap = 0;
    always @(negedge clk) begin
        if (din_ready) rdy_cnt++;
        if (block_done) bd_cnt++;
        if (all_done) ad_cnt++;
        if (error && (block_done || all_done)) overlap++;
    end

    int log_base, rdy_base, bd_base, ad_base;

    function automatic logic [7:0] log_at(input int i);
        if (i < mosi_log.size()) return mosi_log[i];
        else return 8'hxx;
    endfunction

    task automatic run_xfer(input logic m, input logic [31:0] a, input logic [31:0] n, input string tag);
        bit got;
        log_base = mosi_log.size(); rdy_base = rdy_cnt; bd_base = bd_cnt; ad_base = ad_cnt;
        @(negedge clk);
        multi = m; lba_start = a; blocks = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (all_done || error) begin got = 1'b1; break; end
        end
        check_val({tag, "_finished"}, {31'd0, got}, 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_cmd(input logic [7:0] c0, input logic [31:0] a, input string tag);
        logic [7:0] e;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) e = c0;
            else if (k == 5) e = 8'hFF;
            else e = a[8*(4-k) +: 8];
            check_val($sformatf("%s_cmd%0d", tag, k), {24'd0, log_at(log_base + k)}, {24'd0, e});
        end
    endtask

    task automatic check_block(input int off, input int blk, input logic [7:0] tok, input string tag);
        int bad;
        check_val({tag, "_token"}, {24'd0, log_at(log_base + off)}, {24'd0, tok});
        bad = 0;
        for (int j = 0; j < 512; j++)
            if (log_at(log_base + off + 1 + j) !== pat(blk * 512 + j)) bad++;
        check_val({tag, "_data_mismatches"}, bad, 32'd0);
        check_val({tag, "_crc"}, {16'd0, log_at(log_base + off + 513), log_at(log_base + off + 514)}, 32'h0000FFFF);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; multi = 1'b0; lba_start = 32'd0; blocks = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_cs_n", {31'd0, sd_cs_n}, 32'd1);
        check_val("rst_mosi", {24'd0, spi_mosi}, 32'h000000FF);
        check_val("rst_flags", {26'd0, spi_start, din_ready, block_done, all_done, error, 1'b0}, 32'd0);
        check_val("rst_err_code", {29'd0, err_code}, 32'd0);
        check_val("spi_div", {16'd0, spi_div}, 32'd4);

        // Single block
        run_xfer(1'b0, 32'h00001234, 32'd1, "single");
        check_cmd(8'h58, 32'h00001234, "single");
        check_val("single_r1poll_gap", {16'd0, log_at(log_base + 6), log_at(log_base + 7)}, 32'h0000FFFF);
        check_block(8, 0, 8'hFE, "single");
        check_val("single_busy_polls", {log_at(log_base + 524), log_at(log_base + 525), log_at(log_base + 526), log_at(log_base + 527)}, 32'hFFFFFFFF);
        check_val("single_bytes", mosi_log.size() - log_base, 32'd528);
        check_val("single_ready", rdy_cnt - rdy_base, 32'd512);
        check_val("single_bdone", bd_cnt - bd_base, 32'd1);
        check_val("single_adone", ad_cnt - ad_base, 32'd1);
        check_val("single_cs_n", {31'd0, sd_cs_n}, 32'd1);
        check_val("single_error", {31'd0, error}, 32'd0);

        // Multi block, three blocks
        run_xfer(1'b1, 32'h00000010, 32'd3, "multi3");
        check_cmd(8'h59, 32'h00000010, "multi3");
        for (int b = 0; b < 3; b++)
            check_block(8 + b * 521, b, 8'hFC, $sformatf("multi3_b%0d", b));
        check_val("multi3_stop", {16'd0, log_at(log_base + 1570), log_at(log_base + 1571)}, 32'h0000FDFF);
        check_val("multi3_bytes", mosi_log.size() - log_base, 32'd1576);
        check_val("multi3_ready", rdy_cnt - rdy_base, 32'd1536);
        check_val("multi3_bdone", bd_cnt - bd_base, 32'd3);
        check_val("multi3_adone", ad_cnt - ad_base, 32'd1);
        check_val("multi3_cs_n", {31'd0, sd_cs_n}, 32'd1);

        // Multi with blocks=0 behaves as one block
        run_xfer(1'b1, 32'hFFFFFFFF, 32'd0, "multi0");
        check_cmd(8'h59, 32'hFFFFFFFF, "multi0");
        check_block(8, 0, 8'hFC, "multi0");
        check_val("multi0_bytes", mosi_log.size() - log_base, 32'd534);
        check_val("multi0_bdone", bd_cnt - bd_base, 32'd1);
        check_val("multi0_adone", ad_cnt - ad_base, 32'd1);

        // Upstream stall
        stall_en = 1'b1;
        begin
            int hits0, starts0, csbad0;
            hits0 = stall_hits; starts0 = stall_starts; csbad0 = stall_cs_bad;
            run_xfer(1'b0, 32'h00000200, 32'd1, "stall");
            check_val("stall_happened", stall_hits - hits0, 32'd1);
            check_val("stall_starts", stall_starts - starts0, 32'd0);
            check_val("stall_cs_high", stall_cs_bad - csbad0, 32'd0);
        end
        stall_en = 1'b0;
        check_block(8, 0, 8'hFE, "stall");
        check_val("stall_ready", rdy_cnt - rdy_base, 32'd512);
        check_val("stall_adone", ad_cnt - ad_base, 32'd1);

        // R1 reports an error
        r1_val = 8'h04;
        run_xfer(1'b0, 32'h00000001, 32'd1, "r1bad");
        r1_val = 8'h00;
        check_val("r1bad_error", {31'd0, error}, 32'd1);
        check_val("r1bad_code", {29'd0, err_code}, 32'd1);
        check_val("r1bad_cs_n", {31'd0, sd_cs_n}, 32'd1);
        check_val("r1bad_ready", rdy_cnt - rdy_base, 32'd0);

        // R1 never arrives
        r1_never = 1'b1;
        run_xfer(1'b0, 32'h00000002, 32'd1, "r1to");
        r1_never = 1'b0;
        check_val("r1to_code", {29'd0, err_code}, 32'd2);
        check_val("r1to_bytes", mosi_log.size() - log_base, 32'd22);
        check_val("r1to_cs_n", {31'd0, sd_cs_n}, 32'd1);

        // Data response rejected
        dresp_val = 8'hEB;
        run_xfer(1'b0, 32'h00000003, 32'd1, "dresp");
        dresp_val = 8'hE5;
        check_val("dresp_code", {29'd0, err_code}, 32'd3);
        check_val("dresp_bdone", bd_cnt - bd_base, 32'd0);
        check_val("dresp_adone", ad_cnt - ad_base, 32'd0);

        // Card stays busy forever
        busy_forever = 1'b1;
        run_xfer(1'b0, 32'h00000004, 32'd1, "busyto");
        busy_forever = 1'b0;
        check_val("busyto_code", {29'd0, err_code}, 32'd4);
        check_val("busyto_bytes", mosi_log.size() - log_base, 32'd540);
        check_val("busyto_bdone", bd_cnt - bd_base, 32'd0);

        // Reset in the middle of the payload
        begin
            bit reached;
            rdy_base = rdy_cnt;
            @(negedge clk);
            multi = 1'b0; lba_start = 32'h00000005; blocks = 32'd1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            reached = 1'b0;
            for (int i = 0; i < 20000; i++) begin
                @(negedge clk);
                if (rdy_cnt - rdy_base >= 300) begin reached = 1'b1; break; end
            end
            check_val("abort_reached_300", {31'd0, reached}, 32'd1);
            rst = 1'b1;
            @(negedge clk);
            check_val("abort_cs_n", {31'd0, sd_cs_n}, 32'd1);
            check_val("abort_mosi", {24'd0, spi_mosi}, 32'h000000FF);
            check_val("abort_flags", {27'd0, spi_start, din_ready, block_done, all_done, error}, 32'd0);
            check_val("abort_err_code", {29'd0, err_code}, 32'd0);
            rst = 1'b0;
            repeat (2) @(negedge clk);
        end
        run_xfer(1'b0, 32'h0000ABCD, 32'd1, "after_abort");
        check_cmd(8'h58, 32'h0000ABCD, "after_abort");
        check_block(8, 0, 8'hFE, "after_abort");
        check_val("after_abort_ready", rdy_cnt - rdy_base, 32'd512);
        check_val("after_abort_adone", ad_cnt - ad_base, 32'd1);
        check_val("after_abort_error", {31'd0, error}, 32'd0);

        check_val("spi_protocol_violations", viol, 32'd0);
        check_val("done_with_error_overlap", overlap, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
